// File: rtl/note_synth_if.sv
// Note-request / audio-status bundle between the score sequencer and note_synth.
interface note_synth_if;
  logic        note_load;
  logic [2:0]  note_number;
  logic [1:0]  octave;
  logic        stop;
  logic [31:0] tone;
  logic        audio;
  logic        playing;
  logic        pending;

  modport master (
    output note_load, note_number, octave, stop,
    input  tone, audio, playing, pending
  );

  modport slave (
    input  note_load, note_number, octave, stop,
    output tone, audio, playing, pending
  );
endinterface

// File: rtl/note_synth.sv
// Note index + octave to integer-Hz tone and a glitch-free square wave on audio.
// Optional macro NOTE_DURATION_EN: silence the note after DUR_CYCLES without a new note.
module note_synth #(
  parameter int unsigned CLK_HZ     = 100000000,
  parameter int unsigned DUR_CYCLES = 25000000
) (
  input  logic        clk,
  input  logic        rst_n,
  note_synth_if.slave bus
);

  localparam int unsigned CNT_W  = 20;
  localparam int unsigned TONE_W = 32;
  localparam int unsigned IDX_W  = 5;
  localparam int unsigned TAB_N  = 21;
  localparam logic [2:0]  NOTE_REST = 3'd7;

  typedef enum logic {S_IDLE, S_PLAY} state_t;

  // Frequency ROM, indexed by octave*7 + note.
  function automatic logic [TONE_W-1:0] freq_hz(input logic [IDX_W-1:0] idx);
    case (idx)
      5'd0:  return 32'd131;  5'd1:  return 32'd147;  5'd2:  return 32'd165;
      5'd3:  return 32'd174;  5'd4:  return 32'd196;  5'd5:  return 32'd220;
      5'd6:  return 32'd247;  5'd7:  return 32'd262;  5'd8:  return 32'd294;
      5'd9:  return 32'd330;  5'd10: return 32'd349;  5'd11: return 32'd392;
      5'd12: return 32'd440;  5'd13: return 32'd494;  5'd14: return 32'd524;
      5'd15: return 32'd588;  5'd16: return 32'd660;  5'd17: return 32'd698;
      5'd18: return 32'd784;  5'd19: return 32'd880;  5'd20: return 32'd988;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [TAB_N-1:0][CNT_W-1:0] build_half();
    logic [TAB_N-1:0][CNT_W-1:0] tab;
    tab = '0;
    for (int i = 0; i < int'(TAB_N); i++) begin
      tab[i] = CNT_W'(CLK_HZ / (32'd2 * freq_hz(IDX_W'(i))));
    end
    return tab;
  endfunction

  // Half-period counts are fixed at elaboration; no runtime divider.
  localparam logic [TAB_N-1:0][CNT_W-1:0] HALF_TAB = build_half();

  function automatic logic [IDX_W-1:0] idx_of(input logic [2:0] note, input logic [1:0] oct);
    logic [1:0] oct_eff;
    oct_eff = (oct == 2'd3) ? 2'd1 : oct;
    return IDX_W'(IDX_W'(oct_eff) * 5'd7 + IDX_W'(note));
  endfunction

  function automatic logic [CNT_W-1:0] half_of(input logic [IDX_W-1:0] idx);
    return (idx < IDX_W'(TAB_N)) ? HALF_TAB[idx] : '0;
  endfunction

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    half_q, half_d;
  logic [TONE_W-1:0]   tone_q, tone_d;
  logic                audio_q, audio_d;
  logic                playing_q, playing_d;
  logic                pend_q, pend_d;
  logic [2:0]          pend_note_q, pend_note_d;
  logic [1:0]          pend_oct_q, pend_oct_d;
  logic                boundary_c;
  logic                apply_c;
  logic                timeout_c;
  logic                silence_c;
  logic [IDX_W-1:0]    load_idx_c;
  logic [IDX_W-1:0]    pend_idx_c;

`ifdef NOTE_DURATION_EN
  logic [31:0]         dur_q, dur_d;
`else
  wire                 unused_dur = ^DUR_CYCLES;
`endif

  assign bus.tone    = tone_q;
  assign bus.audio   = audio_q;
  assign bus.playing = playing_q;
  assign bus.pending = pend_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      half_q      <= '0;
      tone_q      <= '0;
      audio_q     <= 1'b0;
      playing_q   <= 1'b0;
      pend_q      <= 1'b0;
      pend_note_q <= '0;
      pend_oct_q  <= '0;
`ifdef NOTE_DURATION_EN
      dur_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      half_q      <= half_d;
      tone_q      <= tone_d;
      audio_q     <= audio_d;
      playing_q   <= playing_d;
      pend_q      <= pend_d;
      pend_note_q <= pend_note_d;
      pend_oct_q  <= pend_oct_d;
`ifdef NOTE_DURATION_EN
      dur_q       <= dur_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    half_d      = half_q;
    tone_d      = tone_q;
    audio_d     = audio_q;
    playing_d   = playing_q;
    pend_d      = pend_q;
    pend_note_d = pend_note_q;
    pend_oct_d  = pend_oct_q;
    apply_c     = 1'b0;
    load_idx_c  = idx_of(bus.note_number, bus.octave);
    pend_idx_c  = idx_of(pend_note_q, pend_oct_q);
    boundary_c  = (state_q == S_PLAY) && (cnt_q == half_q - CNT_W'(1));
`ifdef NOTE_DURATION_EN
    timeout_c   = (state_q == S_PLAY) && (dur_q == DUR_CYCLES - 32'd1);
`else
    timeout_c   = 1'b0;
`endif
    silence_c   = bus.stop || timeout_c;

    if (silence_c) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      tone_d    = '0;
      audio_d   = 1'b0;
      playing_d = 1'b0;
      pend_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.note_load && bus.note_number != NOTE_REST) begin
            state_d   = S_PLAY;
            cnt_d     = '0;
            audio_d   = 1'b0;
            half_d    = half_of(load_idx_c);
            tone_d    = freq_hz(load_idx_c);
            playing_d = 1'b1;
            apply_c   = 1'b1;
          end
        end
        S_PLAY: begin
          if (boundary_c) begin
            cnt_d   = '0;
            audio_d = ~audio_q;
            pend_d  = 1'b0;
            if (pend_q) begin
              if (pend_note_q == NOTE_REST) begin
                state_d   = S_IDLE;
                tone_d    = '0;
                audio_d   = 1'b0;
                playing_d = 1'b0;
              end else begin
                half_d  = half_of(pend_idx_c);
                tone_d  = freq_hz(pend_idx_c);
                apply_c = 1'b1;
              end
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          // A load on the boundary cycle is held for the following boundary.
          if (bus.note_load) begin
            pend_d      = 1'b1;
            pend_note_d = bus.note_number;
            pend_oct_d  = bus.octave;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

`ifdef NOTE_DURATION_EN
    if (silence_c || apply_c || state_q != S_PLAY) dur_d = '0;
    else                                          dur_d = dur_q + 32'd1;
`endif
  end

endmodule

// File: tb/tb_note_synth.sv
// Directed bench for note_synth at CLK_HZ=10000 (A4 half-period 11 cycles).
module tb_note_synth;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  note_synth_if bus ();

  note_synth #(.CLK_HZ(10000), .DUR_CYCLES(100)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic load(input logic [2:0] note, input logic [1:0] oct);
    bus.note_load   = 1'b1;
    bus.note_number = note;
    bus.octave      = oct;
    tick();
    bus.note_load   = 1'b0;
  endtask

  task automatic do_stop();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
  endtask

  task automatic chk_silent(input string tag);
    chk({tag, "_tone"},    bus.tone, 32'd0);
    chk({tag, "_audio"},   32'(bus.audio), 32'd0);
    chk({tag, "_playing"}, 32'(bus.playing), 32'd0);
    chk({tag, "_pending"}, 32'(bus.pending), 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.note_load   = 1'b0;
    bus.note_number = 3'd0;
    bus.octave      = 2'd0;
    bus.stop        = 1'b0;
    tick();
    chk_silent("reset");
    tick();
    rst_n = 1'b1;
    tick();

    // Mid A from IDLE: H=11, first high 11 cycles after entering PLAY
    load(3'd5, 2'd1);
    chk("a4_tone", bus.tone, 32'd440);
    chk("a4_playing", 32'(bus.playing), 32'd1);
    chk("a4_audio0", 32'(bus.audio), 32'd0);
    chk("a4_pending", 32'(bus.pending), 32'd0);
    ticks(10); chk("a4_c10", 32'(bus.audio), 32'd0);
    tick();    chk("a4_c11", 32'(bus.audio), 32'd1);
    ticks(10); chk("a4_c21", 32'(bus.audio), 32'd1);
    tick();    chk("a4_c22", 32'(bus.audio), 32'd0);

    // stop and load together: stop wins
    bus.note_load = 1'b1; bus.note_number = 3'd0; bus.octave = 2'd1; bus.stop = 1'b1;
    tick();
    bus.note_load = 1'b0; bus.stop = 1'b0;
    chk_silent("stop_load");
    tick();
    chk("stop_load_stays", 32'(bus.playing), 32'd0);

    // Low A: H=22
    load(3'd5, 2'd0);
    chk("a3_tone", bus.tone, 32'd220);
    ticks(21); chk("a3_c21", 32'(bus.audio), 32'd0);
    tick();    chk("a3_c22", 32'(bus.audio), 32'd1);
    do_stop();

    // High A: H=5
    load(3'd5, 2'd2);
    chk("a5_tone", bus.tone, 32'd880);
    ticks(4); chk("a5_c4", 32'(bus.audio), 32'd0);
    tick();   chk("a5_c5", 32'(bus.audio), 32'd1);
    ticks(5); chk("a5_c10", 32'(bus.audio), 32'd0);
    do_stop();

    // Octave 3 behaves as mid
    load(3'd2, 2'd3);
    chk("oct3_tone", bus.tone, 32'd330);
    do_stop();

    // Rest from IDLE is ignored
    load(3'd7, 2'd1);
    chk_silent("idle_rest");

    // Pending note waits for the boundary; no short half-period
    load(3'd5, 2'd1);
    ticks(3);
    load(3'd0, 2'd1);
    chk("pend_set", 32'(bus.pending), 32'd1);
    chk("pend_old_tone", bus.tone, 32'd440);
    ticks(6);
    chk("pend_c10_pending", 32'(bus.pending), 32'd1);
    chk("pend_c10_audio", 32'(bus.audio), 32'd0);
    tick();
    chk("pend_applied_tone", bus.tone, 32'd262);
    chk("pend_cleared", 32'(bus.pending), 32'd0);
    chk("pend_audio_hi", 32'(bus.audio), 32'd1);
    ticks(18); chk("c4_c18", 32'(bus.audio), 32'd1);
    tick();    chk("c4_c19", 32'(bus.audio), 32'd0);

    // Last load wins: E then G, only G applied
    load(3'd2, 2'd1);
    load(3'd4, 2'd1);
    ticks(16);
    chk("lw_before_tone", bus.tone, 32'd262);
    chk("lw_before_pend", 32'(bus.pending), 32'd1);
    tick();
    chk("lw_tone", bus.tone, 32'd392);
    chk("lw_audio", 32'(bus.audio), 32'd1);
    ticks(11); chk("g4_c11", 32'(bus.audio), 32'd1);
    tick();    chk("g4_c12", 32'(bus.audio), 32'd0);

    // Load on a boundary cycle is deferred one full half-period
    ticks(11);
    load(3'd5, 2'd1);
    chk("bnd_tone_kept", bus.tone, 32'd392);
    chk("bnd_pending", 32'(bus.pending), 32'd1);
    ticks(11);
    chk("bnd_still_392", bus.tone, 32'd392);
    tick();
    chk("bnd_applied", bus.tone, 32'd440);
    chk("bnd_pend_clr", 32'(bus.pending), 32'd0);

    // Pending rest silences at the boundary
    load(3'd7, 2'd1);
    ticks(9);
    chk("rest_still_playing", 32'(bus.playing), 32'd1);
    tick();
    chk_silent("rest_applied");

    // Async reset mid-period clears everything including a pending note
    load(3'd5, 2'd1);
    ticks(13);
    load(3'd0, 2'd1);
    chk("rst_pre_audio", 32'(bus.audio), 32'd1);
    chk("rst_pre_pending", 32'(bus.pending), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_silent("async_rst");
    #1 rst_n = 1'b1;
    ticks(15);
    chk_silent("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/note_synth.md
Name: note_synth

Overview:
- Converts a note index (0..6 = C..B, 7 = rest) plus an octave select into the note frequency in Hz on `tone`, and into a square-wave `audio` output driven from the system clock.
- Sits between the key/score sequencer and the audio pin.
- Its `tone` encoding is the same integer-Hz encoding the tone-number classifier decodes back into a note index.
- Note changes are glitch-free: a new note takes effect only at a square-wave half-period boundary.

Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz; half-period counts are elaboration-time constants derived from it.
- DUR_CYCLES, 25000000, note length in clock cycles; used only when NOTE_DURATION_EN is defined.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- note_load  input  1  single-cycle strobe; captures note_number and octave.
- note_number  input  3  0..6 = C,D,E,F,G,A,B; 7 = rest.
- octave  input  2  0 = low, 1 = mid, 2 = high, 3 = treated as mid.
- stop  input  1  single-cycle strobe; silence immediately.
- tone  output  32  current frequency in Hz; 0 when silent.
- audio  output  1  square wave at frequency `tone`.
- playing  output  1  high while a non-rest note is sounding.
- pending  output  1  high while a loaded note waits for the next boundary.

Behaviour:
- Frequency table (Hz):
  - low: 131 147 165 174 196 220 247
  - mid: 262 294 330 349 392 440 494
  - high: 524 588 660 698 784 880 988
- Half-period count H = floor(CLK_HZ / (2*f)).
  - 20-bit counter; max H at the default is 381679 (low C).
  - Mid A at default = 113636.
- Reset (async, rst_n low): all outputs 0 (tone, audio, playing, pending), counter 0, pending note cleared.
- States:
  - IDLE: silent. audio=0, tone=0, playing=0.
  - PLAY: counter runs 0..H-1. At count H-1 the counter returns to 0 and audio toggles; this is the "boundary".
- IDLE + note_load with note 0..6:
  - Next cycle: PLAY, counter=0, audio=0, tone=f, playing=1.
  - First rising edge of audio occurs H cycles after entering PLAY.
- IDLE + note_load with note 7: remain IDLE; no change.
- PLAY + note_load:
  - The note is registered as pending (pending=1). Repeated loads before the boundary overwrite it: last wins.
  - At the boundary the pending note is applied: new H, tone updates that cycle, counter=0, pending=0.
  - Applied rest (7): enter IDLE. audio forced 0, tone=0, playing=0.
  - Re-loading the note already sounding is still applied at the boundary; the waveform is unchanged.
- Boundary with no pending note: the same note continues.
- stop (any state): next cycle IDLE, all outputs 0, pending cleared.
- stop and note_load in the same cycle: stop wins; the load is discarded.
- note_load coincident with a boundary: the load is applied at the next boundary, not the current one.
- Reset mid-note: immediate silence; no pending state survives.

Optional Feature:
- Macro NOTE_DURATION_EN.
- Defined:
  - A duration counter restarts each time a note is applied (from IDLE or at a boundary).
  - After DUR_CYCLES cycles with no new note applied, the block goes IDLE exactly as for stop.
  - A pending note at timeout is discarded.
- Not defined: a note sounds indefinitely until stop, a rest, or reset. The duration counter is not instantiated.

Test Plan:
- CLK_HZ=10000, load note 5 octave 1 from IDLE -> tone=440, playing=1 next cycle; audio toggles every 11 cycles (first high at cycle 11).
- CLK_HZ=10000, load note 5 octave 0, then octave 2 -> low: tone=220, toggles every 22 cycles; high: tone=880, toggles every 5 cycles.
- Playing 440, load note 0 octave 1 at count 3 -> pending=1 until the boundary at count 10; then tone=262, H=19, pending=0, and no audio half-period shorter than 11 occurs.
- Playing, load note 2 then note 4 before the boundary -> only note 4 (tone=392) applied; note 2 never appears.
- Playing, assert stop and note_load in the same cycle -> next cycle tone=0, audio=0, playing=0, pending=0. Separately, load note 7 -> silent at the next boundary. Assert rst_n low mid-period -> outputs 0 asynchronously.
- NOTE_DURATION_EN, DUR_CYCLES=100, CLK_HZ=10000, play note 5 -> IDLE after 100 cycles. A new note applied at cycle 50 restarts the timer, giving a timeout at cycle 50 + boundary offset + 100.
